complex_mult_sequencer: RTL

Sequential signed complex multiplier: computes (a_r + j·a_i)·(b_r + j·b_i) by time-sharing a single WIDTH×WIDTH signed real multiplier over four cycles under FSM control. It has a start/done handshake and registered, held results. It is the area-reduced, clocked replacement for the combinational four-multiplier complex product in the Exp8 datapath.

---
 rtl/complex_mult_sequencer.sv | 114 +++++++++++
 1 files changed

// File: rtl/complex_mult_sequencer.sv
// Sequential signed complex multiplier: one shared WIDTHxWIDTH multiplier is
// time-shared over four cycles, with a start/done handshake and held results.
module complex_mult_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic signed [WIDTH-1:0]   areal,
  input  logic signed [WIDTH-1:0]   aimaginary,
  input  logic signed [WIDTH-1:0]   breal,
  input  logic signed [WIDTH-1:0]   bimaginary,
  output logic                      busy,
  output logic                      done,
  output logic signed [2*WIDTH-1:0] resultreal,
  output logic signed [2*WIDTH-1:0] resultimaginary
);

  typedef enum logic [2:0] {
    IDLE,
    MUL0,
    MUL1,
    MUL2,
    MUL3,
    DONE
  } state_t;

  state_t state, state_next;

  logic signed [WIDTH-1:0]   op_ar, op_ai, op_br, op_bi;
  logic signed [WIDTH-1:0]   mul_x, mul_y;
  logic signed [2*WIDTH-1:0] product;
  logic signed [2*WIDTH-1:0] acc_real, acc_imag;

  // Both operands are signed, so the product is sign-extended to 2*WIDTH.
  assign product = mul_x * mul_y;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    mul_x      = '0;
    mul_y      = '0;
    case (state)
      IDLE: if (start) state_next = MUL0;
      MUL0: begin
        mul_x      = op_ar;
        mul_y      = op_br;
        state_next = MUL1;
      end
      MUL1: begin
        mul_x      = op_ai;
        mul_y      = op_bi;
        state_next = MUL2;
      end
      MUL2: begin
        mul_x      = op_ar;
        mul_y      = op_bi;
        state_next = MUL3;
      end
      MUL3: begin
        mul_x      = op_ai;
        mul_y      = op_br;
        state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Accumulation wraps modulo 2^(2*WIDTH); results only change on the MUL3 edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_ar           <= '0;
      op_ai           <= '0;
      op_br           <= '0;
      op_bi           <= '0;
      acc_real        <= '0;
      acc_imag        <= '0;
      resultreal      <= '0;
      resultimaginary <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      busy <= (state_next != IDLE);
      done <= (state == MUL3);
      case (state)
        IDLE: begin
          if (start) begin
            op_ar    <= areal;
            op_ai    <= aimaginary;
            op_br    <= breal;
            op_bi    <= bimaginary;
            acc_real <= '0;
            acc_imag <= '0;
          end
        end
        MUL0: acc_real <= acc_real + product;
        MUL1: acc_real <= acc_real - product;
        MUL2: acc_imag <= acc_imag + product;
        MUL3: begin
          acc_imag        <= acc_imag + product;
          resultreal      <= acc_real;
          resultimaginary <= acc_imag + product;
        end
        default: ;
      endcase
    end
  end

endmodule
